reset_sequencer: RTL
====================

# reset_sequencer

Staged reset release controller that sits directly downstream of the chip reset synchronizer. It consumes the synchronized active-low reset and drives NUM_STAGES ordered active-low reset outputs, one per subsystem. Each output is released only after a minimum hold time and after the previous subsystem reports ready; a per-stage timeout bounds the wait. It also supports a synchronous software-requested re-sequence.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs; must be ≥ 1.
- STAGE_DELAY, 16: minimum cycles between consecutive releases; must be ≥ 1.
- TIMEOUT, 1024: maximum cycles to wait for stage_done; must be ≥ STAGE_DELAY.
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset, driven by the reset synchronizer output (asynchronous assert, synchronous deassert).
- sw_rst_req  input  1  synchronous request pulse to re-run the sequence.
- stage_done  input  NUM_STAGES  level-sensitive ready from each released subsystem, synchronous to clk.
- rst_n_out  output  NUM_STAGES  sequenced active-low resets; bit 0 is released first.
- seq_done  output  1  high once every stage has been released and acknowledged.
- timeout_err  output  NUM_STAGES  sticky per-stage flag: that stage advanced on timeout.
- cur_stage  output  $clog2(NUM_STAGES+1)  index of the stage being waited on; NUM_STAGES when in DONE.

## Operation
- States:
  - HOLD: all outputs asserted; count STAGE_DELAY cycles.
  - WAIT(i): rst_n_out[0..i] released; wait for stage i.
  - DONE.
- Async reset (rst_n_in low) forces the following immediately, whatever the clock is doing: HOLD; counter 0; rst_n_out all 0; seq_done 0; timeout_err all 0; cur_stage 0.
- HOLD → WAIT(0) when the counter completes STAGE_DELAY cycles. rst_n_out[0] is set to 1 on that edge.
- WAIT(i) completes on the k-th edge after entry, when one of these holds:
  - k ≥ STAGE_DELAY and stage_done[i] was 1 in the preceding cycle.
  - k = TIMEOUT. timeout_err[i] is then set to 1.
- If both completion conditions hold on the same edge, the stage_done path wins and timeout_err[i] is not set.
- On completion of WAIT(i) for i < NUM_STAGES-1: rst_n_out[i+1] is set to 1, the next state is WAIT(i+1), and the counter clears.
- On completion of WAIT(NUM_STAGES-1): the next state is DONE and seq_done is set to 1.
- stage_done[j] is ignored outside WAIT(j). Deassertion of stage_done after its stage has completed has no effect.
- sw_rst_req high on an edge, in any state:
  - next state is HOLD; counter clears.
  - rst_n_out goes to all 0; seq_done goes to 0.
  - timeout_err is retained; only rst_n_in clears it.
- sw_rst_req held high keeps the block in HOLD with the counter at 0. Release begins STAGE_DELAY edges after the last edge on which it was sampled high.
- Released bits never re-assert except via sw_rst_req or rst_n_in.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Edge 1 is the first rising edge that samples rst_n_in high.
- With stage_done tied high:
  - rst_n_out[i] rises on edge (i+1)·STAGE_DELAY.
  - seq_done rises on edge (NUM_STAGES+1)·STAGE_DELAY.
- With stage_done tied low, each WAIT lasts exactly TIMEOUT edges.
- All outputs are registered, with no combinational path from input to output.
- sw_rst_req takes effect on the edge that samples it: outputs are low from that edge onward.

## Structure
- Shared package reset_pkg holds:
  - the state enum: HOLD, WAIT, DONE.
  - the function computing the counter width.
  - parameter legality checks (elaboration-time assertions on NUM_STAGES, STAGE_DELAY, TIMEOUT).
- One natural sub-module, reset_stage_timer, instantiated once. It is a saturating counter with:
  - a clear input.
  - min_reached (k ≥ STAGE_DELAY) and timed_out (k = TIMEOUT) outputs.
- The FSM, stage index and output registers stay in reset_sequencer.

## Test plan
- Case 1. Setup: NUM_STAGES=3, STAGE_DELAY=4, TIMEOUT=10; stage_done=3'b111; deassert rst_n_in. Required:
  - rst_n_out reads 001 at edge 4, 011 at edge 8, 111 at edge 12.
  - seq_done=1 at edge 16; timeout_err=000.
- Case 2. Same parameters; stage_done[1]=0 permanently. Required:
  - WAIT(1) lasts 10 edges; rst_n_out[2] rises at edge 18.
  - timeout_err=010; seq_done=1 at edge 22.
- Case 3. Same parameters; stage_done[0] rises at edge 9. Required: rst_n_out[1] rises at edge 10, not at 8.
- Case 4. Same parameters; pulse sw_rst_req at edge 9 while in WAIT(1). Required:
  - rst_n_out=000 and seq_done=0 from edge 9.
  - Re-release of rst_n_out[0] at edge 13.
  - timeout_err is unchanged.
- Case 5. Same parameters; assert rst_n_in asynchronously mid-cycle while in DONE. Required:
  - All outputs reach reset values before the next edge.
  - timeout_err=000.
  - The sequence restarts per Case 1 after deassertion.
- Case 6. NUM_STAGES=1, STAGE_DELAY=1, TIMEOUT=1; stage_done=0. Required: rst_n_out[0] rises at edge 1, seq_done at edge 2, timeout_err=1.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types and helpers for the staged reset release controller.
package reset_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must be able to hold the value TIMEOUT.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic bit params_ok(input int unsigned num_stages,
                                     input int unsigned stage_delay,
                                     input int unsigned timeout);
        return (num_stages >= 1) && (stage_delay >= 1) && (timeout >= stage_delay);
    endfunction

endpackage

// File: rtl/reset_stage_timer.sv
// Saturating per-stage edge counter; flags describe the edge about to happen,
// so both outputs come straight from flops.
module reset_stage_timer
    import reset_pkg::*;
#(
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic min_reached_o,
    output logic timed_out_o
);

    localparam int unsigned   CW      = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic          MIN_RST = (STAGE_DELAY <= 1);
    localparam logic          TO_RST  = (TIMEOUT == 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          min_q, min_d;
    logic          to_q, to_d;

    // cnt_q = edges elapsed since entry; the next edge is number cnt_q+1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        min_d = ((32'(cnt_d) + 32'd1) >= STAGE_DELAY);
        to_d  = ((32'(cnt_d) + 32'd1) == TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            min_q <= MIN_RST;
            to_q  <= TO_RST;
        end else begin
            cnt_q <= cnt_d;
            min_q <= min_d;
            to_q  <= to_d;
        end
    end

    assign min_reached_o = min_q;
    assign timed_out_o   = to_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release controller: releases rst_n_out bits in order, gated by
// a minimum hold time and the previous stage's ready, bounded by a timeout.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n_in,
    input  logic                                sw_rst_req,
    input  logic [NUM_STAGES-1:0]               stage_done,
    output logic [NUM_STAGES-1:0]               rst_n_out,
    output logic                                seq_done,
    output logic [NUM_STAGES-1:0]               timeout_err,
    output logic [$clog2(NUM_STAGES+1)-1:0]     cur_stage
);

    localparam int unsigned SW = $clog2(NUM_STAGES + 1);

    if (!params_ok(NUM_STAGES, STAGE_DELAY, TIMEOUT)) begin : g_bad_params
        $error("reset_sequencer: illegal NUM_STAGES/STAGE_DELAY/TIMEOUT");
    end

    state_e                state_q, state_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic [NUM_STAGES-1:0] terr_q, terr_d;
    logic                  seq_done_q, seq_done_d;

    logic                  clear_c;
    logic                  min_reached, timed_out;
    logic                  stage_ok_c;
    logic [NUM_STAGES-1:0] sel_mask_c, next_mask_c;

    reset_stage_timer #(
        .STAGE_DELAY (STAGE_DELAY),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n_in),
        .clear_i       (clear_c),
        .min_reached_o (min_reached),
        .timed_out_o   (timed_out)
    );

    // One-hot of the stage being waited on and of its successor.
    always_comb begin
        sel_mask_c  = '0;
        next_mask_c = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            sel_mask_c[i]  = (stage_q == SW'(i));
            next_mask_c[i] = ((stage_q + SW'(1)) == SW'(i));
        end
    end

    assign stage_ok_c = min_reached && (|(stage_done & sel_mask_c));

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        rst_d      = rst_q;
        terr_d     = terr_q;
        seq_done_d = seq_done_q;
        clear_c    = 1'b0;

        case (state_q)
            HOLD: begin
                if (min_reached) begin
                    state_d  = WAIT;
                    stage_d  = '0;
                    rst_d[0] = 1'b1;
                    clear_c  = 1'b1;
                end
            end
            WAIT: begin
                if (stage_ok_c || timed_out) begin
                    clear_c = 1'b1;
                    // A ready seen on the timeout edge still counts as a clean release.
                    if (!stage_ok_c) begin
                        terr_d = terr_q | sel_mask_c;
                    end
                    if (stage_q == SW'(NUM_STAGES - 1)) begin
                        state_d    = DONE;
                        stage_d    = SW'(NUM_STAGES);
                        seq_done_d = 1'b1;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        rst_d   = rst_q | next_mask_c;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        // Software re-sequence overrides everything except the sticky timeout flags.
        if (sw_rst_req) begin
            state_d    = HOLD;
            stage_d    = '0;
            rst_d      = '0;
            seq_done_d = 1'b0;
            terr_d     = terr_q;
            clear_c    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= HOLD;
            stage_q    <= '0;
            rst_q      <= '0;
            terr_q     <= '0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            rst_q      <= rst_d;
            terr_q     <= terr_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign rst_n_out   = rst_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = terr_q;
    assign cur_stage   = stage_q;

endmodule
